// File: rtl/ads_pkg.sv
// Shared types and constants for the ADS1118 sample averager.
// Configuration macro: ADS_AVG_ALARM_EN (see ads_sample_avg.sv).
package ads_pkg;

    // Accumulate samples, then spend one cycle presenting the block average.
    typedef enum logic {
        ACC  = 1'b0,
        EMIT = 1'b1
    } ads_state_e;

    // ADS1118 full-scale codes; either one means the input clipped.
    localparam logic [15:0] ADS_POS_FS = 16'h7FFF;
    localparam logic [15:0] ADS_NEG_FS = 16'h8000;

    function automatic logic is_full_scale(input logic [15:0] code);
        return (code == ADS_POS_FS) || (code == ADS_NEG_FS);
    endfunction

endpackage

// File: rtl/ads_sample_avg_if.sv
// Bus between the sample source and ads_sample_avg.
//
// Handshake: sample_vld is a one-cycle qualifier for sample_in with no
// backpressure; the averager accepts every pulse, including back-to-back
// pulses. avg_vld is a one-cycle pulse that qualifies a new avg_out, which
// then holds until the next pulse. clr, thr_hi and thr_lo are level inputs.
interface ads_sample_avg_if;
    import ads_pkg::*;

    logic [15:0] sample_in;
    logic        sample_vld;
    logic        clr;
    logic [15:0] thr_hi;
    logic [15:0] thr_lo;
    logic [15:0] avg_out;
    logic        avg_vld;
    logic        sat_flag;
    logic        alarm;
    logic        stale;
    ads_state_e  state_dbg;

    // Sample source side.
    modport master (
        output sample_in, sample_vld, clr, thr_hi, thr_lo,
        input  avg_out, avg_vld, sat_flag, alarm, stale, state_dbg
    );

    // Averager side.
    modport slave (
        input  sample_in, sample_vld, clr, thr_hi, thr_lo,
        output avg_out, avg_vld, sat_flag, alarm, stale, state_dbg
    );

endinterface

// File: rtl/ads_alarm_hyst.sv
// Hysteresis threshold alarm on the block average. Updates only when a new
// average is presented; a value above thr_hi sets, below thr_lo clears, and
// set wins if thresholds are crossed (thr_lo > thr_hi).
module ads_alarm_hyst (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        vld,
    input  logic [15:0] thr_hi,
    input  logic [15:0] thr_lo,
    output logic        alarm
);

    logic above_hi;
    logic below_lo;

    assign above_hi = $signed(value) > $signed(thr_hi);
    assign below_lo = $signed(value) < $signed(thr_lo);

    // Set/clear the alarm on each new average, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else if (vld) begin
            if (above_hi) begin
                alarm <= 1'b1;
            end else if (below_lo) begin
                alarm <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ads_sample_avg.sv
// Block averager for ADS1118 conversion words: sums 2^AVG_LOG2 signed
// samples, presents floor(sum / 2^AVG_LOG2) for one cycle, flags clipped
// blocks and a stalled sample stream.
// Configuration macro: ADS_AVG_ALARM_EN enables the hysteresis alarm;
// without it alarm is tied low and the thresholds are unused.
module ads_sample_avg
    import ads_pkg::*;
#(
    parameter int          AVG_LOG2 = 3,
    parameter logic [15:0] TIMEOUT  = 16'd2000
) (
    input  logic             clk,
    input  logic             rst_n,
    ads_sample_avg_if.slave  bus
);

    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    ads_state_e               state_q;
    ads_state_e               state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     sat_sticky_q;
    logic [15:0]              avg_q;
    logic                     sat_q;
    logic [15:0]              wd_q;
    logic                     avg_vld_c;

    logic                     sample_take;
    logic                     block_done;
    logic                     sample_sat;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [15:0]              avg_next;

    // clr discards a coincident sample, so it can never complete a block.
    assign sample_take = bus.sample_vld && !bus.clr;
    assign block_done  = sample_take && (cnt_q == CNT_LAST);
    assign sample_sat  = is_full_scale(bus.sample_in);
    assign sample_ext  = ACC_W'($signed(bus.sample_in));
    assign acc_sum     = acc_q + sample_ext;
    // Arithmetic shift gives floor division for negative sums.
    assign avg_next    = 16'(acc_sum >>> AVG_LOG2);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: EMIT follows every completed block, even from EMIT.
    always_comb begin
        state_d = ACC;
        case (state_q)
            ACC:     state_d = block_done ? EMIT : ACC;
            EMIT:    state_d = block_done ? EMIT : ACC;
            default: state_d = ACC;
        endcase
    end

    // FSM outputs: the average is announced during the EMIT cycle.
    always_comb begin
        avg_vld_c = 1'b0;
        case (state_q)
            ACC:     avg_vld_c = 1'b0;
            EMIT:    avg_vld_c = 1'b1;
            default: avg_vld_c = 1'b0;
        endcase
    end

    // Accumulator, sample count and per-block clip flag; restart on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            sat_sticky_q <= 1'b0;
        end else if (bus.clr || block_done) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            sat_sticky_q <= 1'b0;
        end else if (bus.sample_vld) begin
            acc_q        <= acc_sum;
            cnt_q        <= cnt_q + 1'b1;
            sat_sticky_q <= sat_sticky_q || sample_sat;
        end
    end

    // Capture the block result so it is visible in the EMIT cycle and held after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_q <= 16'h0000;
            sat_q <= 1'b0;
        end else if (block_done) begin
            avg_q <= avg_next;
            sat_q <= sat_sticky_q || sample_sat;
        end
    end

    // Watchdog: cycles since the last sample, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= 16'd0;
        end else if (bus.sample_vld) begin
            wd_q <= 16'd0;
        end else if (wd_q != TIMEOUT) begin
            wd_q <= wd_q + 16'd1;
        end
    end

`ifdef ADS_AVG_ALARM_EN
    // Alarm is evaluated on the same edge that loads the new average.
    ads_alarm_hyst u_alarm (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (avg_next),
        .vld    (block_done),
        .thr_hi (bus.thr_hi),
        .thr_lo (bus.thr_lo),
        .alarm  (bus.alarm)
    );
`else
    logic unused_thr;
    assign unused_thr = ^{bus.thr_hi, bus.thr_lo};
    assign bus.alarm  = 1'b0;
`endif

    assign bus.avg_out   = avg_q;
    assign bus.avg_vld   = avg_vld_c;
    assign bus.sat_flag  = sat_q;
    assign bus.stale     = (wd_q == TIMEOUT);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ads_sample_avg.sv
// Bench for ads_sample_avg: one instance with AVG_LOG2=3/TIMEOUT=20 driven by
// table vectors, hand sequences and random traffic against a queue-based
// model, plus one AVG_LOG2=2 instance for the clipping sequence.
module tb_ads_sample_avg;
    import ads_pkg::*;

    localparam int N3 = 8;
    localparam int TO = 20;

    logic clk;
    logic rst_n;

    ads_sample_avg_if bus3 ();
    ads_sample_avg_if bus2 ();

    ads_sample_avg #(.AVG_LOG2(3), .TIMEOUT(16'd20)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    ads_sample_avg #(.AVG_LOG2(2), .TIMEOUT(16'd20)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Clock and global time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int errors = 0;
    int checks = 0;

    // Reference model state for dut3.
    logic [15:0] blk_q[$];
    logic [15:0] exp_q[$];
    bit          m_sticky;
    bit          m_sat;
    int          m_idle;
    int          vld_pulses;

    typedef struct {
        string       name;
        logic [15:0] s[8];
        logic [15:0] exp_avg;
        bit          exp_sat;
    } blk_vec_t;

    blk_vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint s, input longint n);
        longint q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic bit is_fs(input logic [15:0] d);
        return (d == 16'h7FFF) || (d == 16'h8000);
    endfunction

    task automatic model_reset();
        blk_q.delete();
        exp_q.delete();
        m_sticky = 0;
        m_sat    = 0;
        m_idle   = 0;
    endtask

    // Drive one cycle on dut3, advance the model, compare outputs.
    task automatic step3(input bit vld, input logic [15:0] data, input bit c);
        bit     m_vld;
        longint s;
        bus3.sample_vld = vld;
        bus3.sample_in  = data;
        bus3.clr        = c;
        @(posedge clk);
        #1;
        m_vld = 0;
        if (c) begin
            blk_q.delete();
            m_sticky = 0;
        end else if (vld) begin
            blk_q.push_back(data);
            if (is_fs(data)) m_sticky = 1;
            if (blk_q.size() == N3) begin
                s = 0;
                foreach (blk_q[i]) s += longint'($signed(blk_q[i]));
                exp_q.push_back(16'(floor_div(s, N3)));
                m_sat    = m_sticky;
                m_sticky = 0;
                blk_q.delete();
                m_vld = 1;
            end
        end
        if (vld) m_idle = 0;
        else if (m_idle < TO) m_idle++;
        check("avg_vld", bus3.avg_vld, m_vld);
        if (bus3.avg_vld) vld_pulses++;
        if (m_vld) check("avg_out", bus3.avg_out, exp_q.pop_front());
        check("sat_flag", bus3.sat_flag, m_sat);
        check("stale", bus3.stale, m_idle >= TO);
        bus3.sample_vld = 1'b0;
        bus3.clr        = 1'b0;
    endtask

    task automatic step2(input bit vld, input logic [15:0] data);
        bus2.sample_vld = vld;
        bus2.sample_in  = data;
        @(posedge clk);
        #1;
        bus2.sample_vld = 1'b0;
    endtask

    task automatic send_block3(input logic [15:0] v);
        for (int j = 0; j < N3; j++) step3(1'b1, v, 1'b0);
    endtask

    int          p0;
    logic [15:0] rd;
    bit          exp_alarm[4];
    logic [15:0] alarm_avg[4];

    initial begin
        tbl[0] = '{"all_100",  '{16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100}, 16'd100, 1'b0};
        tbl[1] = '{"neg_one",  '{16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 16'hFFFF, 1'b0};
        tbl[2] = '{"ramp_pos", '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8}, 16'd4, 1'b0};
        tbl[3] = '{"ramp_neg", '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8}, 16'hFFFB, 1'b0};
        tbl[4] = '{"pos_fs",   '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 1'b1};
        tbl[5] = '{"neg_fs",   '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h8000, 1'b1};
        tbl[6] = '{"zeros",    '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 16'd0, 1'b0};

        // Reset block.
        rst_n = 1'b0;
        bus3.sample_in = '0; bus3.sample_vld = 1'b0; bus3.clr = 1'b0;
        bus3.thr_hi = 16'd1000; bus3.thr_lo = 16'd900;
        bus2.sample_in = '0; bus2.sample_vld = 1'b0; bus2.clr = 1'b0;
        bus2.thr_hi = 16'd1000; bus2.thr_lo = 16'd900;
        model_reset();
        vld_pulses = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avg_out", bus3.avg_out, 16'h0000);
        check("rst_avg_vld", bus3.avg_vld, 1'b0);
        check("rst_sat", bus3.sat_flag, 1'b0);
        check("rst_alarm", bus3.alarm, 1'b0);
        check("rst_stale", bus3.stale, 1'b0);
        check("rst_state", bus3.state_dbg, ACC);
        rst_n = 1'b1;

        // AVG_LOG2=2 clipping sequence.
        for (int j = 0; j < 3; j++) begin
            step2(1'b1, 16'h7FFF);
            check("d2_no_vld", bus2.avg_vld, 1'b0);
        end
        step2(1'b1, 16'h0000);
        check("d2_vld", bus2.avg_vld, 1'b1);
        check("d2_avg", bus2.avg_out, 16'h5FFF);
        check("d2_sat", bus2.sat_flag, 1'b1);
        step2(1'b0, 16'h0000);
        check("d2_vld_pulse", bus2.avg_vld, 1'b0);
        for (int j = 0; j < 3; j++) step2(1'b1, 16'h0000);
        check("d2_sat_held", bus2.sat_flag, 1'b1);
        check("d2_avg_held", bus2.avg_out, 16'h5FFF);
        step2(1'b1, 16'h0000);
        check("d2_vld2", bus2.avg_vld, 1'b1);
        check("d2_avg2", bus2.avg_out, 16'h0000);
        check("d2_sat2", bus2.sat_flag, 1'b0);

        // Table vectors on dut3.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < N3; j++) step3(1'b1, tbl[i].s[j], 1'b0);
            check({"tbl_vld_", tbl[i].name}, bus3.avg_vld, 1'b1);
            check({"tbl_avg_", tbl[i].name}, bus3.avg_out, tbl[i].exp_avg);
            check({"tbl_sat_", tbl[i].name}, bus3.sat_flag, tbl[i].exp_sat);
            step3(1'b0, 16'h0000, 1'b0);
        end

        // Back-to-back 16 samples, then clr part way through a third block.
        p0 = vld_pulses;
        for (int j = 0; j < 16; j++) step3(1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        step3(1'b0, 16'h0000, 1'b0);
        check("b2b_pulses", vld_pulses - p0, 2);
        for (int j = 0; j < 3; j++) step3(1'b1, 16'($urandom_range(0, 4000)), 1'b0);
        step3(1'b1, 16'h1234, 1'b1);
        for (int j = 0; j < 7; j++) step3(1'b1, 16'($urandom_range(0, 4000)), 1'b0);
        check("clr_no_early_vld", vld_pulses - p0, 2);
        step3(1'b1, 16'd40, 1'b0);
        check("clr_vld_after_8", bus3.avg_vld, 1'b1);
        // clr raised during the EMIT cycle leaves that avg_vld asserted.
        bus3.clr = 1'b1;
        #1;
        check("clr_in_emit_vld", bus3.avg_vld, 1'b1);
        step3(1'b0, 16'h0000, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       rd = 16'h7FFF;
                1:       rd = 16'h8000;
                default: rd = 16'($urandom_range(0, 65535));
            endcase
            step3($urandom_range(0, 2) != 0, rd, $urandom_range(0, 24) == 0);
        end

        // Alarm hysteresis.
        step3(1'b0, 16'h0000, 1'b1);
        send_block3(16'd0);
        alarm_avg = '{16'd950, 16'd1001, 16'd950, 16'd899};
`ifdef ADS_AVG_ALARM_EN
        exp_alarm = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        exp_alarm = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            send_block3(alarm_avg[i]);
            check("alarm", bus3.alarm, exp_alarm[i]);
        end

        // Watchdog boundary.
        step3(1'b0, 16'h0000, 1'b1);
        for (int j = 0; j < TO - 2; j++) step3(1'b0, 16'h0000, 1'b0);
        check("stale_before", bus3.stale, 1'b0);
        step3(1'b0, 16'h0000, 1'b0);
        check("stale_set", bus3.stale, 1'b1);
        step3(1'b1, 16'd5, 1'b0);
        check("stale_clear", bus3.stale, 1'b0);

        // Asynchronous reset mid-block.
        step3(1'b1, 16'd5, 1'b0);
        step3(1'b1, 16'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_avg_out", bus3.avg_out, 16'h0000);
        check("arst_avg_vld", bus3.avg_vld, 1'b0);
        check("arst_sat", bus3.sat_flag, 1'b0);
        check("arst_alarm", bus3.alarm, 1'b0);
        check("arst_stale", bus3.stale, 1'b0);
        check("arst_state", bus3.state_dbg, ACC);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = vld_pulses;
        for (int j = 0; j < 5; j++) step3(1'b1, 16'd64, 1'b0);
        check("arst_partial_gone", vld_pulses - p0, 0);
        for (int j = 0; j < 3; j++) step3(1'b1, 16'd64, 1'b0);
        check("arst_full_block", bus3.avg_out, 16'd64);
        step3(1'b0, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ads_sample_avg.md
ADS_SAMPLE_AVG -- requirements
Module: ads_sample_avg

Interface
REQ-001 Parameter AVG_LOG2, default 3, log2 of samples per averaged block (legal range 0..6).
REQ-002 Parameter TIMEOUT, default 16'd2000, clk cycles allowed between sample_vld pulses before stale is flagged.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sample_in  input  16  raw ADS1118 conversion word, signed two's complement.
REQ-006 sample_vld  input  1  one-cycle pulse, sample_in valid this cycle.
REQ-007 clr  input  1  synchronous discard of the partial block.
REQ-008 thr_hi  input  16  signed alarm set threshold.
REQ-009 thr_lo  input  16  signed alarm clear threshold.
REQ-010 avg_out  output  16  signed block average, held between updates.
REQ-011 avg_vld  output  1  one-cycle pulse when avg_out updates.
REQ-012 sat_flag  output  1  the last completed block contained at least one sample equal to 16'h7FFF or 16'h8000.
REQ-013 alarm  output  1  hysteresis threshold alarm.
REQ-014 stale  output  1  no sample_vld for TIMEOUT cycles.

Function
REQ-015 States: ACC (accumulating) and EMIT (output cycle); reset enters ACC.
REQ-016 In ACC, each sample_vld sign-extends sample_in into an accumulator of width 16+AVG_LOG2 and increments sample count.
REQ-017 A sample_vld arriving when count = 2^AVG_LOG2-1 completes the block: next state EMIT.
REQ-018 In EMIT: avg_out = (sum including final sample) >>> AVG_LOG2, arithmetic shift, rounding toward negative infinity; avg_vld = 1 for exactly this cycle; latency from final sample_vld to avg_vld is 1 cycle.
REQ-019 The accumulator and count are zeroed on block completion; a sample_vld during EMIT is accepted as sample 1 of the next block, with no sample lost and no stall.
REQ-020 AVG_LOG2 = 0: every sample_vld produces avg_out = sample_in one cycle later.
REQ-021 sat_flag: a per-block sticky bit is set by a saturated code; it is copied to sat_flag in EMIT and then cleared.
REQ-022 clr: zeroes the accumulator, count and sticky saturation bit, and returns to ACC; clr with sample_vld in the same cycle discards that sample; clr during EMIT does not suppress that avg_vld.
REQ-023 The watchdog counter resets on every sample_vld and saturates at TIMEOUT.
REQ-024 stale = 1 while watchdog = TIMEOUT; stale clears the cycle after the next sample_vld.

Reset
REQ-025 rst_n low immediately forces: state ACC, accumulator 0, count 0, avg_out 16'h0000, avg_vld 0, sat_flag 0, alarm 0, stale 0, watchdog 0.
REQ-026 Reset mid-block discards the partial block; the first block after reset needs a full 2^AVG_LOG2 samples.

Configuration
REQ-027 Macro ADS_AVG_ALARM_EN defined: alarm sets in EMIT when the new avg_out > thr_hi and clears in EMIT when the new avg_out < thr_lo, comparisons signed; otherwise it holds.
REQ-028 If avg_out > thr_hi and avg_out < thr_lo simultaneously (misprogrammed thresholds), set wins.
REQ-029 Macro not defined: alarm is tied to 0, thr_hi and thr_lo are ignored, and no comparator logic is synthesized.

Structure
REQ-030 Package ads_pkg holds the state enum (ACC, EMIT) and the constants ADS_POS_FS = 16'h7FFF and ADS_NEG_FS = 16'h8000.
REQ-031 The hysteresis comparator is sub-module ads_alarm_hyst (inputs: value, vld, thr_hi, thr_lo; output: alarm); it is instantiated only under ADS_AVG_ALARM_EN.

Verification
REQ-032 AVG_LOG2=3; feed eight samples of 100 -> one avg_vld, 1 cycle after the 8th sample, avg_out = 100, sat_flag = 0.
REQ-033 AVG_LOG2=3; feed samples -1,0,0,0,0,0,0,0 -> avg_out = 16'hFFFF (floor of -1/8).
REQ-034 AVG_LOG2=2; samples 7FFF,7FFF,7FFF,0 -> avg_out = 16'h5FFF, sat_flag = 1; next block of 4 zeros -> sat_flag = 0.
REQ-035 Back-to-back sample_vld every cycle for 16 samples with AVG_LOG2=3 -> exactly two avg_vld pulses and no sample dropped; clr asserted after sample 3 of a third block -> the next avg_vld needs 8 new samples.
REQ-036 ALARM_EN, thr_hi=1000, thr_lo=900; block averages 950, 1001, 950, 899 -> alarm 0, 1, 1, 0.
REQ-037 TIMEOUT=20; no sample_vld for 20 cycles -> stale = 1; assert rst_n low mid-block -> all outputs read 0 immediately.
